// File: rtl/bless_inject_queue_pkg.sv
// Shared definitions for the BLESS injection queue.
// Control word layout (CONTROL_N bits):
//   [VALID_BIT]          flit valid bit (MSB)
//   [AGE_MSB:AGE_LSB]    age field used by the age-ordered arbiter
//   [AGE_LSB-1:0]        remaining routing/control bits, carried unchanged
// Optional feature macro used by the design: BLESS_INJ_AGE_EN.
package bless_inject_queue_pkg;

  localparam int CONTROL_N   = 12;
  localparam int CONTROL_W   = CONTROL_N - 1;
  localparam int VALID_BIT   = CONTROL_W;
  localparam int AGE_N       = 3;
  localparam int AGE_LSB     = 8;
  localparam int AGE_MSB     = AGE_LSB + AGE_N - 1;
  localparam int INJ_STALL_W = 16;

  // A locally generated flit enters the queue as valid with age zero.
  function automatic logic [CONTROL_N-1:0] enq_format(input logic [CONTROL_N-1:0] ctl);
    logic [CONTROL_N-1:0] res;
    res                  = ctl;
    res[VALID_BIT]       = 1'b1;
    res[AGE_MSB:AGE_LSB] = '0;
    return res;
  endfunction

endpackage

// File: rtl/bless_inject_fifo_mem.sv
// Storage array of the injection queue with read/write pointers and occupancy.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   push, pop              write / read strobes (qualified by the caller)
//   wr_control, wr_data    entry written on push
//   rd_control, rd_data    raw entry at the read pointer
//   rd_ptr                 read pointer (only with BLESS_INJ_AGE_EN)
//   count                  occupancy, 0..DEPTH
module bless_inject_fifo_mem
  import bless_inject_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [CONTROL_N-1:0]     wr_control,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [CONTROL_N-1:0]     rd_control,
  output logic [DATA_W-1:0]        rd_data,
`ifdef BLESS_INJ_AGE_EN
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CONTROL_N-1:0] ctl_mem  [DEPTH];
  logic [DATA_W-1:0]    data_mem [DEPTH];
  logic [PTR_W-1:0]     rd_q;
  logic [PTR_W-1:0]     wr_q;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      count <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ctl_mem[wr_q]  <= wr_control;
      data_mem[wr_q] <= wr_data;
    end
  end

  assign rd_control = ctl_mem[rd_q];
  assign rd_data    = data_mem[rd_q];

`ifdef BLESS_INJ_AGE_EN
  assign rd_ptr = rd_q;
`endif

endmodule

// File: rtl/bless_inject_queue.sv
// Injection-side FIFO of a BLESS deflection router. Presents the head flit as
// the injection channel and injects only when a network channel is free.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enq_valid/enq_ready       local core handshake
//   enq_control, enq_data     offered flit
//   net_valid[3:0]            valid bits of the four network input channels
//   control_out, data_out     head flit (zero when empty)
//   ready_out                 head injected this cycle
//   count                     occupancy
//   starve                    head blocked >= STARVE_LIMIT consecutive cycles
// Optional macro BLESS_INJ_AGE_EN: queued flits age while waiting.
module bless_inject_queue
  import bless_inject_queue_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [CONTROL_N-1:0]   enq_control,
  input  logic [DATA_W-1:0]      enq_data,
  input  logic [3:0]             net_valid,
  output logic [CONTROL_N-1:0]   control_out,
  output logic [DATA_W-1:0]      data_out,
  output logic                   ready_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   starve
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   free;
  logic                   push;
  logic                   pop;
  logic [CONTROL_N-1:0]   head_control;
  logic [CONTROL_N-1:0]   head_ctl_aged;
  logic [DATA_W-1:0]      head_data;
  logic [INJ_STALL_W-1:0] stall_q;
  logic [INJ_STALL_W-1:0] stall_next;

  assign free      = ~&net_valid;
  assign pop       = (count != '0) && free;
  assign enq_ready = (count != CNT_W'(DEPTH));
  assign push      = enq_valid && enq_ready;
  assign ready_out = pop;

`ifdef BLESS_INJ_AGE_EN
  localparam int PTR_W = $clog2(DEPTH);
  logic [PTR_W-1:0] rd_ptr;
`endif

  bless_inject_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .wr_control (enq_format(enq_control)),
    .wr_data    (enq_data),
    .rd_control (head_control),
    .rd_data    (head_data),
`ifdef BLESS_INJ_AGE_EN
    .rd_ptr     (rd_ptr),
`endif
    .count      (count)
  );

`ifdef BLESS_INJ_AGE_EN
  // Ages live beside the storage array; the stored age field stays zero and
  // the live age is overlaid on the head word.
  logic [AGE_N-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] occupied;
  logic [PTR_W-1:0] offs;
  logic [PTR_W-1:0] wr_slot;

  assign wr_slot = rd_ptr + count[PTR_W-1:0];

  always_comb begin
    occupied = '0;
    offs     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs        = PTR_W'(i) - rd_ptr;
      occupied[i] = ({1'b0, offs} < count);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && PTR_W'(i) == wr_slot)
        age_q[i] <= '0;
      else if (occupied[i] && !(pop && PTR_W'(i) == rd_ptr) && age_q[i] != '1)
        age_q[i] <= age_q[i] + 1'b1;
    end
  end

  always_comb begin
    head_ctl_aged                  = head_control;
    head_ctl_aged[AGE_MSB:AGE_LSB] = age_q[rd_ptr];
  end
`else
  assign head_ctl_aged = head_control;
`endif

  // Storage is not reset, so an empty queue must not expose stale entries.
  assign control_out = (count == '0) ? '0 : head_ctl_aged;
  assign data_out    = (count == '0) ? '0 : head_data;

  always_comb begin
    if (count == '0 || pop) stall_next = '0;
    else if (stall_q == '1) stall_next = stall_q;
    else                    stall_next = stall_q + 1'b1;
  end

  // starve tracks the counter value being loaded, so both change on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      starve  <= 1'b0;
    end else begin
      stall_q <= stall_next;
      starve  <= (stall_next >= INJ_STALL_W'(STARVE_LIMIT));
    end
  end

endmodule

// File: tb/tb_bless_inject_queue.sv
module tb_bless_inject_queue;
  import bless_inject_queue_pkg::*;

  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enq_valid;
  logic                 enq_ready;
  logic [CONTROL_N-1:0] enq_control;
  logic [31:0]          enq_data;
  logic [3:0]           net_valid;
  logic [CONTROL_N-1:0] control_out;
  logic [31:0]          data_out;
  logic                 ready_out;
  logic [2:0]           count;
  logic                 starve;

  int total = 0;
  int bad   = 0;

  bless_inject_queue dut (
    .clk         (clk),
    .rst         (rst),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_control (enq_control),
    .enq_data    (enq_data),
    .net_valid   (net_valid),
    .control_out (control_out),
    .data_out    (data_out),
    .ready_out   (ready_out),
    .count       (count),
    .starve      (starve)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [CONTROL_N-1:0] ctl;
    logic [31:0]          data;
    int                   age;
  } flit_t;

  flit_t mq[$];
  int    blk    = 0;
  bit    chk_en = 0;

  function automatic logic [CONTROL_N-1:0] model_ctl(input flit_t f);
    logic [2:0] a;
    a = 3'(f.age);
    return {1'b1, a, f.ctl[7:0]};
  endfunction

  // Inputs change just after posedge, so at negedge they are the values the
  // next posedge will sample: compare first, then advance the model.
  always @(negedge clk) begin
    int    sz;
    bit    pm;
    bit    pushm;
    flit_t nf;
    sz = mq.size();
    pm = (sz > 0) && (net_valid != 4'hF);
    if (chk_en) begin
      check("m_count", count, sz);
      check("m_enq_ready", enq_ready, (sz < DEPTH));
      check("m_ready_out", ready_out, pm);
      check("m_control", control_out, (sz > 0) ? model_ctl(mq[0]) : '0);
      check("m_data", data_out, (sz > 0) ? mq[0].data : 32'h0);
      check("m_starve", starve, (blk >= 64));
    end
    if (rst) begin
      mq.delete();
      blk    = 0;
      chk_en = 1;
    end else if (chk_en) begin
      pushm = enq_valid && (sz < DEPTH);
      if (sz == 0 || pm) blk = 0;
      else if (blk < 65535) blk++;
      if (pm) void'(mq.pop_front());
`ifdef BLESS_INJ_AGE_EN
      foreach (mq[j]) if (mq[j].age < 7) mq[j].age = mq[j].age + 1;
`endif
      if (pushm) begin
        nf.ctl  = enq_control;
        nf.data = enq_data;
        nf.age  = 0;
        mq.push_back(nf);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [CONTROL_N-1:0] c, input logic [31:0] d,
                       input logic [3:0] nv, input logic r);
    enq_valid   = ev;
    enq_control = c;
    enq_data    = d;
    net_valid   = nv;
    rst         = r;
  endtask

  logic [CONTROL_N-1:0] age_exp_ctl;

  initial begin
    drive(1'b0, '0, 32'h0, 4'hF, 1'b1);
    tick();
    tick();
    drive(1'b0, '0, 32'h0, 4'hF, 1'b0);
    #1;
    check("rst_count", count, 0);
    check("rst_ready_out", ready_out, 0);
    check("rst_control", control_out, 0);
    check("rst_data", data_out, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_starve", starve, 0);
    tick();

    // A, B, C then inject three in a row
    drive(1'b1, 12'h5A3, 32'hAAAA_0001, 4'hF, 1'b0); tick();
    drive(1'b1, 12'h0F1, 32'hBBBB_0002, 4'hF, 1'b0); tick();
    drive(1'b1, 12'hFFF, 32'hCCCC_0003, 4'hF, 1'b0); tick();
    drive(1'b0, '0, 32'h0, 4'h7, 1'b0);
    #1;
    check("abc_count3", count, 3);
    check("abc_ready_a", ready_out, 1);
    check("abc_ctl_a", control_out, 12'h8A3);
    check("abc_data_a", data_out, 32'hAAAA_0001);
    tick();
    check("abc_ctl_b", control_out, 12'h8F1);
    check("abc_count2", count, 2);
    tick();
    check("abc_ctl_c", control_out, 12'h8FF);
    check("abc_data_c", data_out, 32'hCCCC_0003);
    tick();
    check("abc_empty", count, 0);
    check("abc_ready_off", ready_out, 0);

    // fill to full while blocked
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 12'h010 + 12'(i), 32'hD000_0000 + i, 4'hF, 1'b0);
      tick();
    end
    drive(1'b1, 12'h014, 32'hD000_0004, 4'hF, 1'b0);
    #1;
    check("full_enq_ready", enq_ready, 0);
    check("full_count", count, 4);
    tick();
    check("full_hold_count", count, 4);
    drive(1'b1, 12'h014, 32'hD000_0004, 4'hB, 1'b0);
    #1;
    check("full_pop_ready", ready_out, 1);
    check("full_pop_data", data_out, 32'hD000_0000);
    check("full_pop_enq_ready", enq_ready, 0);
    tick();
    drive(1'b1, 12'h014, 32'hD000_0004, 4'hF, 1'b0);
    #1;
    check("after_pop_count", count, 3);
    check("after_pop_enq_ready", enq_ready, 1);
    tick();
    check("refill_count", count, 4);
    drive(1'b0, '0, 32'h0, 4'h0, 1'b0);
    #1;
    check("drain_first", data_out, 32'hD000_0001);
    for (int i = 0; i < 4; i++) tick();
    check("drain_empty", count, 0);

    // simultaneous push and pop at count 2
    drive(1'b1, 12'h020, 32'hE000_0000, 4'hF, 1'b0); tick();
    drive(1'b1, 12'h021, 32'hE000_0001, 4'hF, 1'b0); tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 12'h022 + 12'(k), 32'hE000_0002 + k, 4'h1, 1'b0);
      #1;
      check("pp_count", count, 2);
      check("pp_data", data_out, 32'hE000_0000 + k);
      tick();
    end
    drive(1'b0, '0, 32'h0, 4'h0, 1'b0);
    tick();
    tick();
    check("pp_drained", count, 0);

    // starvation
`ifdef BLESS_INJ_AGE_EN
    age_exp_ctl = 12'hFC5;
`else
    age_exp_ctl = 12'h8C5;
`endif
    drive(1'b1, 12'h3C5, 32'hF000_0000, 4'hF, 1'b0);
    tick();
    drive(1'b0, '0, 32'h0, 4'hF, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 10) check("age_after_10", control_out, age_exp_ctl);
      if (i == 63) check("starve_63", starve, 0);
      if (i == 64) check("starve_64", starve, 1);
    end
    drive(1'b0, '0, 32'h0, 4'h7, 1'b0);
    #1;
    check("starve_pop_ready", ready_out, 1);
    check("starve_pop_ctl", control_out, age_exp_ctl);
    tick();
    check("starve_cleared", starve, 0);
    check("starve_empty", count, 0);

    // reset mid-stream
    drive(1'b1, 12'h040, 32'h6000_0000, 4'hF, 1'b0); tick();
    drive(1'b1, 12'h041, 32'h6000_0001, 4'hF, 1'b0); tick();
    drive(1'b1, 12'h042, 32'h6000_0002, 4'hF, 1'b0); tick();
    drive(1'b1, 12'h043, 32'h6000_0003, 4'h7, 1'b1);
    #1;
    check("mid_count3", count, 3);
    check("mid_ready", ready_out, 1);
    tick();
    drive(1'b0, '0, 32'h0, 4'hF, 1'b0);
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_ready", ready_out, 0);
    check("mid_rst_stall", dut.stall_q, 0);
    check("mid_rst_starve", starve, 0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bless_inject_queue.md
Name: bless_inject_queue

Overview:
- Injection-side FIFO of a BLESS deflection router.
- Buffers locally generated flits and presents the head flit as the fifth, injection, channel to the age-increment stage.
- Drives that stage's injection control input and its injection ready input.
- Injects only in a cycle when at least one of the four network input channels carries an invalid flit (free slot).

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- DATA_W, 32, payload width carried alongside the control word.
- STARVE_LIMIT, 64, consecutive blocked cycles before starve is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enq_valid  in  1  local core offers a flit
- enq_ready  out  1  queue accepts the flit this cycle
- enq_control  in  `control_n  control word of the offered flit; valid bit is the MSB, age field is `age_f
- enq_data  in  DATA_W  payload of the offered flit
- net_valid  in  4  valid bits of network channels 0..3 in the current cycle
- control_out  out  `control_n  head control word; feeds the injection control input
- data_out  out  DATA_W  head payload
- ready_out  out  1  head is valid and an injection occurs this cycle; feeds the injection ready input
- count  out  $clog2(DEPTH)+1  current occupancy
- starve  out  1  head blocked at least STARVE_LIMIT consecutive cycles

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - Storage contents are don't-care.
  - Read and write pointers, count, stall counter and starve are all 0.
  - control_out is 0; data_out is 0.
  - rst has priority over push and pop in the same cycle; a push in that cycle is lost.
- Derived signals:
  - free = ~&net_valid.
  - pop = (count != 0) & free.
  - ready_out = pop.
  - enq_ready = (count != DEPTH); no push-through when full.
  - push = enq_valid & enq_ready.
- Enqueue:
  - Stores the control word with the MSB forced to 1 and the age field forced to 0.
  - All other control bits and the payload are stored unchanged.
- Head outputs:
  - control_out/data_out are combinational reads of the entry at the read pointer.
  - When count == 0: control_out = 0 and data_out = 0. The downstream stage kills the channel anyway because ready_out = 0.
- Pointer and count updates:
  - Push and pop in the same cycle are legal at any nonzero count; count is unchanged and both pointers advance.
  - Empty queue: push only; the new flit becomes visible as head the next cycle. There is no same-cycle bypass, so zero-to-head latency is 1 cycle.
  - Full queue: pop only is possible in that cycle; enq_ready returns to 1 the following cycle.
  - Pointers wrap modulo DEPTH.
- Stall counter (16 bits, saturating at all ones):
  - Cleared when count == 0 or on pop.
  - Otherwise incremented by 1 each cycle (head present, no free slot).
  - starve = (stall counter >= STARVE_LIMIT); registered, so it updates on the same edge as the counter.
- Flit order is strict FIFO; no flit is dropped or duplicated.

Optional Feature:
- Macro BLESS_INJ_AGE_EN.
- Defined:
  - Each cycle, every occupied entry not being popped has its age field incremented by 1, saturating at all ones in `age_n bits.
  - A flit enqueued this cycle starts at 0.
  - Queuing delay therefore counts toward the flit's priority in the age-ordered arbiter.
- Undefined:
  - Age stays 0 until injection.
  - No per-entry adders are instantiated.

Decomposition:
- Shared package/defines file holds:
  - `control_n, `control_w, `age_n, `age_f and the valid-bit position.
  - An INJ_STALL_W = 16 constant.
- Natural sub-module: bless_inject_fifo_mem, the storage array with read/write pointers and occupancy.
- Stall counter, starve logic and age update stay in the top module.

Test Plan:
- Reset then idle, net_valid=4'b1111: count=0, ready_out=0, control_out=0, enq_ready=1, starve=0.
- Push flits A,B,C with net_valid=4'b1111 for 3 cycles, then net_valid=4'b0111: ready_out=1 for 3 consecutive cycles; control_out MSB=1, age=0; outputs in order A,B,C; count 3→0.
- Fill to DEPTH=4, hold enq_valid=1 and net_valid=4'b1111: enq_ready=0 and count stays 4. Drop net_valid[2] for one cycle: one pop; enq_ready=1 the next cycle; a push is then accepted.
- Simultaneous push and pop at count=2 for 10 cycles: count stays 2; outputs are strictly ordered; pointers wrap correctly.
- Head blocked (net_valid=4'b1111) for 64 cycles: starve rises after the 64th blocked cycle. A single free cycle pops and clears starve the next cycle.
- With BLESS_INJ_AGE_EN and `age_n=3: flit blocked 10 cycles exits with age 7 (saturated). Without the macro, it exits with age 0.
- rst asserted mid-stream with count=3 and push+pop active: next cycle count=0, ready_out=0, stall counter=0.
